instr_mem_loader: RTL and testbench
===================================

Name: instr_mem_loader

Overview:
- Write-side counterpart of the instruction ROM.
- Receives a program as a byte stream (valid/ready) from the debug/UART front end and assembles big-endian 32-bit words.
- Writes the words sequentially into instruction memory starting at word address 0.
- Stops on the HALT word 32'hFFFFFFFF and signals completion so the pipeline can be released from reset.

Parameters:
TAM, 32, instruction word width in bits (fixed at 4 bytes; other values unsupported)
DEPTH, 2048, instruction memory depth in words
ADDR_W, 11, word address width, equal to log2(DEPTH)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset; clears all state
start  input  1  one-cycle pulse that begins a new load
in_valid  input  1  in_byte holds a valid byte
in_byte  input  8  program byte stream, most-significant byte of each word first
in_ready  output  1  loader accepts a byte this cycle
wr_en  output  1  one-cycle instruction-memory write strobe
wr_addr  output  ADDR_W  word address for the write
wr_data  output  TAM  assembled instruction word
loading  output  1  high while in state LOAD
done  output  1  high in DONE (HALT word written); pipeline may run
error  output  1  high in ERR (memory filled with no HALT)
word_count  output  ADDR_W+1  number of words written in the current load

Behaviour:
- Reset (asynchronous, reset=0):
  - State goes to IDLE.
  - All outputs are 0: in_ready, wr_en, wr_addr, wr_data, loading, done, error, word_count.
  - Byte index and assembly shift register are cleared.
- States are IDLE, LOAD, DONE, ERR.
  - IDLE, DONE or ERR with start=1: go to LOAD next cycle. Clear word_count, the address counter and the byte index. Clear done and error.
  - LOAD with start=1: start is ignored.
- in_ready:
  - Equals 1 only in LOAD and not in the cycle wr_en=1.
  - A byte is accepted when in_valid and in_ready are both 1 on a clock edge.
  - in_valid outside LOAD is ignored and no data is lost.
- Assembly: each accepted byte shifts into a 32-bit register as {word[23:0], in_byte}. The byte index counts 0..3.
- 4th byte accepted (index 3):
  - In the next cycle: wr_en=1 for exactly one cycle, wr_data = the assembled word, wr_addr = current address counter.
  - At the end of that cycle: address counter +1, word_count +1, byte index returns to 0.
  - Latency from 4th byte handshake to wr_en is 1 cycle. Maximum throughput is 4 bytes per 5 cycles.
- HALT detect: if the written word equals 32'hFFFFFFFF, it is still written. The state then goes to DONE in the cycle after wr_en, and done=1 with in_ready=0.
- Overflow: if a non-HALT word is written at address DEPTH-1, the state goes to ERR and error=1. No further writes occur and the address never wraps to 0.
- Gaps: in_valid may drop at any time between bytes. A partial word is held indefinitely with no timeout.
- wr_addr and wr_data hold their last values when wr_en=0.
- Reset during LOAD:
  - Any partial word is discarded and no write strobe is issued.
  - Words already written are left in memory.
- word_count stays stable in DONE and ERR until the next start. Maximum value is DEPTH.

Test Plan:
1. Reset low then high; start pulse; stream 00 0B 10 21 -> one cycle after 4th byte: wr_en=1, wr_addr=0, wr_data=32'h000B1021; word_count=1; loading=1.
2. Stream 3 words then FF FF FF FF -> four writes at addresses 0..3 with HALT at address 3; done=1 the next cycle; in_ready=0; word_count=4.
3. Toggle in_valid randomly (about 50% duty) while streaming 12 34 56 78 -> single write of 32'h12345678; in_ready=0 during the wr_en cycle; no byte lost or duplicated.
4. Stream 2048 non-HALT words -> last write at address 2047; then error=1, word_count=2048; further bytes are not accepted; no write to address 0.
5. Assert reset after 2 bytes of the 2nd word -> no wr_en; all outputs 0; a new start with AA BB CC DD writes 32'hAABBCCDD at address 0.
6. In DONE, pulse start and stream FF FF FF FF -> done drops; loading=1; HALT written at address 0; done=1 again with word_count=1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// Program loader for the instruction memory.
// Takes a byte stream (valid/ready) with the most-significant byte of each word first.
// Packs the bytes into big-endian words and writes them to consecutive word addresses from 0.
// A load finishes cleanly on the HALT word 32'hFFFFFFFF. A load that fills every address
// without a HALT word ends in an error state instead.
module instr_mem_loader #(
    parameter int unsigned TAM    = 32,
    parameter int unsigned DEPTH  = 2048,
    parameter int unsigned ADDR_W = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    input  logic [7:0]        in_byte,
    output logic              in_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [TAM-1:0]    wr_data,
    output logic              loading,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   word_count
);

    localparam logic [TAM-1:0]    HaltWord = '1;
    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StDone,
        StErr
    } state_e;

    state_e state_q, state_d;

    // Bytes 0..2 of the word in progress; the 4th byte goes straight into wr_data_q.
    logic [TAM-9:0]    shift_q, shift_d;
    logic [1:0]        byte_idx_q, byte_idx_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   word_count_q, word_count_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [TAM-1:0]    wr_data_q, wr_data_d;

    logic start_load;
    logic accept;
    logic write_halt;
    logic write_last;

    // start is only honoured outside LOAD; a load in progress cannot be restarted
    assign start_load = start && (state_q != StLoad);
    assign accept     = in_valid && in_ready;
    assign write_halt = wr_en_q && (wr_data_q == HaltWord);
    assign write_last = wr_en_q && (wr_addr_q == LastAddr);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                // Leave LOAD in the cycle after the write strobe.
                // HALT takes priority over running out of address space.
                if (write_halt) begin
                    state_d = StDone;
                end else if (write_last) begin
                    state_d = StErr;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs; no byte is taken while a write strobe is out
    always_comb begin
        loading  = (state_q == StLoad);
        done     = (state_q == StDone);
        error    = (state_q == StErr);
        in_ready = (state_q == StLoad) && !wr_en_q;
    end

    // Datapath next-state: byte assembly, write strobe, address and word counters
    always_comb begin
        shift_d      = shift_q;
        byte_idx_d   = byte_idx_q;
        addr_d       = addr_q;
        word_count_d = word_count_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;

        if (start_load) begin
            shift_d      = '0;
            byte_idx_d   = '0;
            addr_d       = '0;
            word_count_d = '0;
        end else if (state_q == StLoad) begin
            if (wr_en_q) begin
                // The write completes this cycle.
                // The address stops at the last word instead of wrapping to 0.
                word_count_d = word_count_q + (ADDR_W + 1)'(1);
                if (addr_q != LastAddr) begin
                    addr_d = addr_q + ADDR_W'(1);
                end
            end else if (accept) begin
                if (byte_idx_q == 2'd3) begin
                    wr_en_d    = 1'b1;
                    wr_data_d  = {shift_q, in_byte};
                    wr_addr_d  = addr_q;
                    shift_d    = '0;
                    byte_idx_d = '0;
                end else begin
                    shift_d    = {shift_q[TAM-17:0], in_byte};
                    byte_idx_d = byte_idx_q + 2'd1;
                end
            end
        end
    end

    // Datapath registers; reset discards any partial word and pending strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            shift_q      <= '0;
            byte_idx_q   <= '0;
            addr_q       <= '0;
            word_count_q <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
        end else begin
            shift_q      <= shift_d;
            byte_idx_q   <= byte_idx_d;
            addr_q       <= addr_d;
            word_count_q <= word_count_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
        end
    end

    // Registered outputs; wr_addr and wr_data keep their values between strobes
    always_comb begin
        wr_en      = wr_en_q;
        wr_addr    = wr_addr_q;
        wr_data    = wr_data_q;
        word_count = word_count_q;
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader.
// The first part applies a table of single-word loads.
// Randomised loads are checked against a word-level reference model.
// Hand-written sequences cover restart, reset during a load, overflow and reload from DONE.
module tb_instr_mem_loader;

    localparam int unsigned TAM    = 32;
    localparam int unsigned DEPTH  = 2048;
    localparam int unsigned ADDR_W = 11;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_byte = 8'h00;
    logic              in_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [TAM-1:0]    wr_data;
    logic              loading;
    logic              done;
    logic              error;
    logic [ADDR_W:0]   word_count;

    instr_mem_loader #(
        .TAM    (TAM),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .loading    (loading),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Every write strobe seen on the memory port, sampled on the falling edge
    typedef struct packed {
        logic [ADDR_W-1:0] a;
        logic [31:0]       d;
    } wr_t;

    wr_t got_q[$];

    always @(negedge clk) begin
        if (reset === 1'b1 && wr_en === 1'b1) begin
            got_q.push_back({wr_addr, wr_data});
            chk("in_ready_low_during_write", 64'(in_ready), 64'd0);
        end
    end

    // Reference model.
    // Cut the byte stream into big-endian words and stop after HALT or after the last address.
    logic [7:0] stim_q[$];
    wr_t        exp_q[$];
    int         exp_used;
    bit         exp_halted;

    task automatic model();
        logic [31:0] w;
        exp_q      = {};
        exp_used   = 0;
        exp_halted = 1'b0;
        for (int i = 0; i * 4 + 3 < stim_q.size(); i++) begin
            w = {stim_q[i*4], stim_q[i*4+1], stim_q[i*4+2], stim_q[i*4+3]};
            exp_q.push_back({ADDR_W'(i), w});
            exp_used = i * 4 + 4;
            if (w == 32'hFFFF_FFFF) begin
                exp_halted = 1'b1;
                break;
            end
            if (i == DEPTH - 1) break;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Offer one byte, optionally after random idle cycles.
    // Returns one cycle after the handshake edge.
    task automatic send_byte(input logic [7:0] b, input bit rnd);
        int n;
        n = 0;
        while (rnd && n < 6 && $urandom_range(0, 1) == 1) begin
            in_valid = 1'b0;
            in_byte  = 8'($urandom);
            tick();
            n++;
        end
        in_valid = 1'b1;
        in_byte  = b;
        n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL byte_accept_timeout: in_ready=%b after %0d cycles, want 1", in_ready, n);
        end else begin
            tick();
        end
        in_valid = 1'b0;
        in_byte  = 8'($urandom);
    endtask

    // Start a load from stim_q and send the bytes the model expects to be consumed.
    // Then check every write and the final status.
    task automatic run_load(input string tag, input bit rnd);
        bit exp_err;
        model();
        got_q = {};
        pulse_start();
        chk({tag, "_loading_after_start"}, 64'(loading), 64'd1);
        chk({tag, "_done_after_start"}, 64'(done), 64'd0);
        chk({tag, "_error_after_start"}, 64'(error), 64'd0);
        chk({tag, "_count_after_start"}, 64'(word_count), 64'd0);
        for (int i = 0; i < exp_used; i++) begin
            send_byte(stim_q[i], rnd);
        end
        repeat (3) tick();
        exp_err = !exp_halted && (exp_q.size() == DEPTH);
        chk({tag, "_num_writes"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) begin
                chk($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
            end else if (i == 0 || i == exp_q.size() - 1) begin
                chk($sformatf("%s_write%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
            end
        end
        chk({tag, "_done"}, 64'(done), 64'(exp_halted));
        chk({tag, "_error"}, 64'(error), 64'(exp_err));
        chk({tag, "_loading"}, 64'(loading), 64'(!exp_halted && !exp_err));
        chk({tag, "_word_count"}, 64'(word_count), 64'(exp_q.size()));
        if (exp_q.size() > 0) begin
            chk({tag, "_wr_addr_hold"}, 64'(wr_addr), 64'(exp_q[exp_q.size()-1].a));
            chk({tag, "_wr_data_hold"}, 64'(wr_data), 64'(exp_q[exp_q.size()-1].d));
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        for (int b = 0; b < 4; b++) begin
            stim_q.push_back(w[31-8*b -: 8]);
        end
    endtask

    typedef struct {
        logic [31:0] word_in;
        logic [31:0] exp_data;
        logic        exp_done;
        logic        exp_loading;
        logic [11:0] exp_cnt;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [31:0] w;
        int          n;
        int          seen;

        vecs[0] = '{32'h000B_1021, 32'h000B_1021, 1'b0, 1'b1, 12'd1};
        vecs[1] = '{32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 12'd1};
        vecs[2] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 12'd1};
        vecs[3] = '{32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0, 1'b1, 12'd1};
        vecs[4] = '{32'hFFFF_FFFE, 32'hFFFF_FFFE, 1'b0, 1'b1, 12'd1};
        vecs[5] = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 12'd1};

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wr_en", 64'(wr_en), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_loading", 64'(loading), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_word_count", 64'(word_count), 64'd0);
        reset = 1'b1;
        tick();

        // Table of single-word loads with cycle-exact strobe timing
        for (int v = 0; v < 6; v++) begin
            reset = 1'b0;
            tick();
            reset = 1'b1;
            tick();
            got_q = {};
            pulse_start();
            for (int b = 0; b < 4; b++) begin
                send_byte(vecs[v].word_in[31-8*b -: 8], 1'b0);
            end
            chk($sformatf("vec%0d_wr_en", v), 64'(wr_en), 64'd1);
            chk($sformatf("vec%0d_wr_addr", v), 64'(wr_addr), 64'd0);
            chk($sformatf("vec%0d_wr_data", v), 64'(wr_data), 64'(vecs[v].exp_data));
            chk($sformatf("vec%0d_in_ready", v), 64'(in_ready), 64'd0);
            tick();
            chk($sformatf("vec%0d_wr_en_drop", v), 64'(wr_en), 64'd0);
            chk($sformatf("vec%0d_word_count", v), 64'(word_count), 64'(vecs[v].exp_cnt));
            tick();
            chk($sformatf("vec%0d_done", v), 64'(done), 64'(vecs[v].exp_done));
            chk($sformatf("vec%0d_loading", v), 64'(loading), 64'(vecs[v].exp_loading));
            chk($sformatf("vec%0d_ready", v), 64'(in_ready), 64'(vecs[v].exp_loading));
        end

        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Three words then HALT, back to back
        stim_q = {};
        push_word(32'h0102_0304);
        push_word(32'hDEAD_BEEF);
        push_word(32'h0000_0013);
        push_word(32'hFFFF_FFFF);
        run_load("three_plus_halt", 1'b0);

        // Random valid gaps on one word, then HALT
        stim_q = {};
        push_word(32'h1234_5678);
        push_word(32'hFFFF_FFFF);
        run_load("gappy", 1'b1);

        // Random programs; trailing bytes after HALT must never be consumed
        for (int r = 0; r < 3; r++) begin
            stim_q = {};
            n = $urandom_range(5, 20);
            for (int i = 0; i < n; i++) begin
                w = $urandom;
                if (w == 32'hFFFF_FFFF) w = 32'h7FFF_FFFF;
                push_word(w);
            end
            push_word(32'hFFFF_FFFF);
            push_word($urandom);
            run_load($sformatf("rand%0d", r), 1'b1);
        end

        // Fill every address with no HALT
        stim_q = {};
        for (int i = 0; i < DEPTH; i++) begin
            push_word({i[15:0], ~i[15:0]});
        end
        run_load("overflow", 1'b0);
        in_valid = 1'b1;
        in_byte  = 8'hFF;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            if (in_ready === 1'b1) seen++;
            tick();
        end
        in_valid = 1'b0;
        chk("overflow_ready_cycles", 64'(seen), 64'd0);
        chk("overflow_no_more_writes", 64'(got_q.size()), 64'(DEPTH));
        chk("overflow_error_held", 64'(error), 64'd1);
        chk("overflow_count_held", 64'(word_count), 64'(DEPTH));

        // Reset after two bytes of the second word
        got_q = {};
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        tick();
        send_byte(8'h55, 1'b0);
        send_byte(8'h66, 1'b0);
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_wr_en", 64'(wr_en), 64'd0);
        chk("midrst_wr_addr", 64'(wr_addr), 64'd0);
        chk("midrst_wr_data", 64'(wr_data), 64'd0);
        chk("midrst_loading", 64'(loading), 64'd0);
        chk("midrst_word_count", 64'(word_count), 64'd0);
        repeat (2) tick();
        chk("midrst_writes", 64'(got_q.size()), 64'd1);
        reset = 1'b1;
        tick();
        stim_q = {};
        push_word(32'hAABB_CCDD);
        run_load("after_reset", 1'b0);

        // start inside LOAD is ignored: the word in progress and the address carry on
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        got_q = {};
        pulse_start();
        send_byte(8'h11, 1'b0);
        send_byte(8'h22, 1'b0);
        pulse_start();
        send_byte(8'h33, 1'b0);
        send_byte(8'h44, 1'b0);
        tick();
        for (int b = 0; b < 4; b++) send_byte(8'hA0 + 8'(b), 1'b0);
        tick();
        chk("restart_ignored_writes", 64'(got_q.size()), 64'd2);
        if (got_q.size() == 2) begin
            chk("restart_ignored_w0", 64'(got_q[0]), 64'({ADDR_W'(0), 32'h1122_3344}));
            chk("restart_ignored_w1", 64'(got_q[1]), 64'({ADDR_W'(1), 32'hA0A1_A2A3}));
        end
        chk("restart_ignored_count", 64'(word_count), 64'd2);

        // Reload from DONE
        reset = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        stim_q = {};
        push_word(32'h0000_0001);
        push_word(32'hFFFF_FFFF);
        run_load("to_done", 1'b0);
        stim_q = {};
        push_word(32'hFFFF_FFFF);
        run_load("reload_from_done", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
